ri5cy_data_mem_responder: RTL and testbench



---
 rtl/ri5cy_mem_pkg.sv | 12 +
 rtl/ri5cy_resp_pipe.sv | 42 ++++
 rtl/ri5cy_data_mem_responder.sv | 138 +++++++++++++
 tb/tb_ri5cy_data_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ri5cy_mem_pkg.sv
// Shared types and constants for the RI5CY data-memory responder.
package ri5cy_mem_pkg;

  localparam int BYTE_LANES       = 4;
  localparam int WORD_OFFSET_BITS = 2;

  typedef logic [BYTE_LANES-1:0] be_t;
  typedef logic [31:0]           word_t;

  typedef enum logic {IDLE, WAIT} gnt_state_e;

endpackage

// File: rtl/ri5cy_resp_pipe.sv
// Fixed-depth valid/data shift register carrying responses from grant to rvalid.
module ri5cy_resp_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    vld_d = '0;
    for (int i = 0; i < DEPTH; i++) data_d[i] = '0;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // Data lanes carry no reset; the output mask below hides stale contents.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = vld_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

endmodule

// File: rtl/ri5cy_data_mem_responder.sv
// Memory-side slave for the RI5CY data bus: delayed grant, byte-enabled RAM,
// fixed-latency in-order responses, and load/store/stall counters.
module ri5cy_data_mem_responder
  import ri5cy_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WORDS    = 1024,
  parameter int GNT_DELAY    = 0,
  parameter int RESP_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic                    stall_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic [31:0]             load_count,
  output logic [31:0]             store_count,
  output logic [31:0]             stall_count
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] DLY_INIT = CNT_W'((GNT_DELAY > 0) ? GNT_DELAY - 1 : 0);

  gnt_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      load_count_q, load_count_d;
  logic [31:0]      store_count_q, store_count_d;
  logic [31:0]      stall_count_q, stall_count_d;
  logic             gnt, fire;

  word_t            ram [MEM_WORDS];
  word_t            ram_rdata;
  logic [IDX_W-1:0] word_idx;
  logic             unused_addr;

  // High address bits are dropped so accesses wrap modulo the RAM size.
  assign word_idx    = data_addr_i[IDX_W+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
  assign unused_addr = ^{data_addr_i[ADDR_WIDTH-1:IDX_W+WORD_OFFSET_BITS],
                         data_addr_i[WORD_OFFSET_BITS-1:0]};
  assign ram_rdata   = ram[word_idx];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt        = 1'b0;
    if (GNT_DELAY == 0) begin
      gnt = data_req_i & ~stall_i;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (data_req_i && !stall_i) begin
            state_d    = WAIT;
            wait_cnt_d = DLY_INIT;
          end
        end
        WAIT: begin
          if (!data_req_i) begin
            state_d = IDLE;
          end else if (!stall_i) begin
            if (wait_cnt_q == '0) begin
              gnt     = 1'b1;
              state_d = IDLE;
            end else begin
              wait_cnt_d = wait_cnt_q - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign fire = gnt & data_req_i;

  always_comb begin
    load_count_d  = load_count_q;
    store_count_d = store_count_q;
    stall_count_d = stall_count_q;
    if (fire && data_we_i)  store_count_d = store_count_q + 32'd1;
    if (fire && !data_we_i) load_count_d  = load_count_q + 32'd1;
    if (data_req_i && !gnt) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      load_count_q  <= '0;
      store_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      load_count_q  <= load_count_d;
      store_count_q <= store_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire && data_we_i) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (data_be_i[i]) ram[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
      end
    end
  end

  ri5cy_resp_pipe #(
    .DEPTH (RESP_LATENCY),
    .WIDTH (DATA_WIDTH)
  ) u_resp_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (fire),
    .in_data  (data_we_i ? '0 : ram_rdata),
    .out_vld  (data_rvalid_o),
    .out_data (data_rdata_o)
  );

  assign data_gnt_o  = gnt;
  assign load_count  = load_count_q;
  assign store_count = store_count_q;
  assign stall_count = stall_count_q;

`ifndef SYNTHESIS
  req_held_in_wait: assert property (@(posedge clk) disable iff (rst)
    (state_q == WAIT) |-> data_req_i)
    else $error("data_req_i dropped while waiting for grant");
`endif

endmodule

// File: tb/tb_ri5cy_data_mem_responder.sv
// Directed bench: a zero-delay instance driven from a vector table and a
// delayed-grant, deep-latency instance driven by hand-written sequences.
module tb_ri5cy_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: GNT_DELAY=0, RESP_LATENCY=2
  logic        a_rst, a_req, a_we, a_stall;
  logic [15:0] a_addr;
  logic [3:0]  a_be;
  logic [31:0] a_wd;
  logic        a_gnt, a_rv;
  logic [31:0] a_rd, a_ld, a_st, a_sc;

  // Instance B: GNT_DELAY=3, RESP_LATENCY=4
  logic        b_rst, b_req, b_we, b_stall;
  logic [15:0] b_addr;
  logic [3:0]  b_be;
  logic [31:0] b_wd;
  logic        b_gnt, b_rv;
  logic [31:0] b_rd, b_ld, b_st, b_sc;

  ri5cy_data_mem_responder #(.GNT_DELAY(0), .RESP_LATENCY(2)) dut_a (
    .clk(clk), .rst(a_rst), .data_req_i(a_req), .data_addr_i(a_addr),
    .data_we_i(a_we), .data_be_i(a_be), .data_wdata_i(a_wd), .stall_i(a_stall),
    .data_gnt_o(a_gnt), .data_rvalid_o(a_rv), .data_rdata_o(a_rd),
    .load_count(a_ld), .store_count(a_st), .stall_count(a_sc));

  ri5cy_data_mem_responder #(.GNT_DELAY(3), .RESP_LATENCY(4)) dut_b (
    .clk(clk), .rst(b_rst), .data_req_i(b_req), .data_addr_i(b_addr),
    .data_we_i(b_we), .data_be_i(b_be), .data_wdata_i(b_wd), .stall_i(b_stall),
    .data_gnt_o(b_gnt), .data_rvalid_o(b_rv), .data_rdata_o(b_rd),
    .load_count(b_ld), .store_count(b_st), .stall_count(b_sc));

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        stall;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
  } avec_t;

  localparam int NA = 19;
  avec_t av [NA];

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } bexp_t;
  bexp_t bq [$];
  int    bcyc = 0;

  task automatic b_cycle(input logic req, input logic we, input logic [15:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic stall,
                         input logic rst_v, input logic exp_gnt, input logic [31:0] exp_rd);
    logic        exp_v;
    logic [31:0] exp_d;
    b_req = req; b_we = we; b_addr = addr; b_be = be; b_wd = wd;
    b_stall = stall; b_rst = rst_v;
    @(negedge clk);
    exp_v = (bq.size() > 0) && (bq[0].cyc == bcyc);
    exp_d = exp_v ? bq[0].d : 32'h0;
    check($sformatf("b_gnt@%0d", bcyc), 32'(b_gnt), 32'(exp_gnt));
    check($sformatf("b_rvalid@%0d", bcyc), 32'(b_rv), 32'(exp_v));
    check($sformatf("b_rdata@%0d", bcyc), b_rd, exp_d);
    if (exp_v) void'(bq.pop_front());
    if (exp_gnt && !rst_v) bq.push_back('{bcyc + 4, we ? 32'h0 : exp_rd});
    if (rst_v) bq.delete();
    bcyc++;
    @(posedge clk); #1;
  endtask

  // One request held until granted; smask[i] drives stall_i on its i-th cycle.
  task automatic b_op(input logic we, input logic [15:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [15:0] smask, input int nwait,
                      input logic [31:0] exp_rd);
    for (int i = 0; i <= nwait; i++)
      b_cycle(1'b1, we, addr, be, wd, smask[i], 1'b0, (i == nwait), exp_rd);
  endtask

  task automatic b_idle(input int n);
    for (int i = 0; i < n; i++)
      b_cycle(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic b_counts(input string tag, input logic [31:0] ld, input logic [31:0] st,
                          input logic [31:0] sc);
    check({tag, "_load_count"}, b_ld, ld);
    check({tag, "_store_count"}, b_st, st);
    check({tag, "_stall_count"}, b_sc, sc);
  endtask

  initial begin
    int eld, est, esc;

    //         req  we    addr      be    wdata          stall  gnt   rv    rdata
    av[0]  = '{1'b1, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
    av[1]  = '{1'b1, 1'b0, 16'h0010, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
    av[2]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    av[3]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    av[4]  = '{1'b1, 1'b1, 16'h0010, 4'h5, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'h0};
    av[5]  = '{1'b1, 1'b0, 16'h0010, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
    av[6]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    av[7]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDE22BE44};
    av[8]  = '{1'b1, 1'b1, 16'h1000, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h0};
    av[9]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
    av[10] = '{1'b1, 1'b0, 16'h0010, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    av[11] = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
    av[12] = '{1'b1, 1'b1, 16'h0010, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0};
    av[13] = '{1'b1, 1'b0, 16'h0010, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    av[14] = '{1'b1, 1'b0, 16'h0010, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
    av[15] = '{1'b1, 1'b0, 16'h1000, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
    av[16] = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDE22BE44};
    av[17] = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
    av[18] = '{1'b0, 1'b0, 16'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};

    a_rst = 1'b1; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_be = '0; a_wd = '0; a_stall = 1'b0;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wd = '0; b_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset state of both instances
    @(negedge clk);
    check("a_rst_gnt", 32'(a_gnt), 32'h0);
    check("a_rst_rvalid", 32'(a_rv), 32'h0);
    check("a_rst_rdata", a_rd, 32'h0);
    check("a_rst_load_count", a_ld, 32'h0);
    check("a_rst_store_count", a_st, 32'h0);
    check("a_rst_stall_count", a_sc, 32'h0);
    check("b_rst_rvalid", 32'(b_rv), 32'h0);
    check("b_rst_rdata", b_rd, 32'h0);
    b_counts("b_rst", 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Instance A vector table
    eld = 0; est = 0; esc = 0;
    for (int k = 0; k < NA; k++) begin
      a_req = av[k].req; a_we = av[k].we; a_addr = av[k].addr;
      a_be = av[k].be; a_wd = av[k].wd; a_stall = av[k].stall;
      @(negedge clk);
      check($sformatf("a%0d_gnt", k), 32'(a_gnt), 32'(av[k].gnt));
      check($sformatf("a%0d_rvalid", k), 32'(a_rv), 32'(av[k].rv));
      check($sformatf("a%0d_rdata", k), a_rd, av[k].rd);
      check($sformatf("a%0d_load_count", k), a_ld, 32'(eld));
      check($sformatf("a%0d_store_count", k), a_st, 32'(est));
      check($sformatf("a%0d_stall_count", k), a_sc, 32'(esc));
      if (av[k].gnt) begin
        if (av[k].we) est++;
        else          eld++;
      end else if (av[k].req) begin
        esc++;
      end
      @(posedge clk); #1;
    end
    a_req = 1'b0; a_stall = 1'b0;
    @(negedge clk);
    check("a_final_load_count", a_ld, 32'd5);
    check("a_final_store_count", a_st, 32'd4);
    check("a_final_stall_count", a_sc, 32'd2);
    @(posedge clk); #1;

    // Instance B: three back-to-back stores, grant after three wait cycles each
    b_op(1'b1, 16'h0020, 4'hF, 32'h11111111, 16'h0, 3, 32'h0);
    b_op(1'b1, 16'h0024, 4'hF, 32'h22222222, 16'h0, 3, 32'h0);
    b_op(1'b1, 16'h0028, 4'hF, 32'h33333333, 16'h0, 3, 32'h0);
    b_idle(6);
    b_counts("b_stores", 32'd0, 32'd3, 32'd9);

    b_cycle(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    b_counts("b_clear", 32'd0, 32'd0, 32'd0);

    // Three loads with req held continuously
    b_op(1'b0, 16'h0020, 4'h0, 32'h0, 16'h0, 3, 32'h11111111);
    b_op(1'b0, 16'h0024, 4'h0, 32'h0, 16'h0, 3, 32'h22222222);
    b_op(1'b0, 16'h0028, 4'h0, 32'h0, 16'h0, 3, 32'h33333333);
    b_idle(6);
    b_counts("b_loads", 32'd3, 32'd0, 32'd9);

    // Back-pressure for 5 cycles from IDLE, then stall freezing the WAIT counter
    b_op(1'b0, 16'h0028, 4'h0, 32'h0, 16'h001F, 8, 32'h33333333);
    b_op(1'b0, 16'h0020, 4'h0, 32'h0, 16'h0006, 5, 32'h11111111);
    b_idle(6);
    b_counts("b_stall", 32'd5, 32'd0, 32'd22);

    // Reset two cycles after a load grant: its response must never appear
    b_op(1'b0, 16'h0024, 4'h0, 32'h0, 16'h0, 3, 32'h22222222);
    b_idle(1);
    b_cycle(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    b_idle(8);
    b_counts("b_midrst", 32'd0, 32'd0, 32'd0);

    // RAM survives reset
    b_op(1'b0, 16'h0024, 4'h0, 32'h0, 16'h0, 3, 32'h22222222);
    b_idle(5);
    b_counts("b_after", 32'd1, 32'd0, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
